// File: rtl/fifo_burst_rd_pkg.sv
// Shared types and constants for the FIFO burst reader and its output buffer.
package fifo_burst_rd_pkg;

    typedef enum logic [0:0] {
        FBR_IDLE,
        FBR_DRAIN
    } fbr_state_e;

    localparam int FBR_OBUF_DEPTH = 2;

    // Occupancy needs to represent 0..FBR_OBUF_DEPTH inclusive.
    typedef logic [1:0] fbr_occ_t;

    localparam fbr_occ_t FBR_OCC_EMPTY = fbr_occ_t'(0);
    localparam fbr_occ_t FBR_OCC_ONE   = fbr_occ_t'(1);
    localparam fbr_occ_t FBR_OCC_FULL  = fbr_occ_t'(FBR_OBUF_DEPTH);

endpackage

// File: rtl/fifo_burst_rd_obuf.sv
// Two-entry in-order skid buffer between the FIFO pop port and the output stream.
// The head register reads as zero whenever the buffer is empty.
module fifo_burst_rd_obuf
    import fifo_burst_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    input  logic                  rd_en_i,
    output fbr_occ_t              occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    fbr_occ_t              occ_q;
    logic                  do_rd;

    assign do_rd = rd_en_i & (occ_q != FBR_OCC_EMPTY);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= FBR_OCC_EMPTY;
        end else begin
            case (occ_q)
                FBR_OCC_EMPTY: begin
                    if (wr_en_i) begin
                        head_q <= wr_dat_i;
                        occ_q  <= FBR_OCC_ONE;
                    end
                end
                FBR_OCC_ONE: begin
                    // Write while the head leaves: the new word takes the head slot directly.
                    if (wr_en_i && do_rd) begin
                        head_q <= wr_dat_i;
                    end else if (wr_en_i) begin
                        tail_q <= wr_dat_i;
                        occ_q  <= FBR_OCC_FULL;
                    end else if (do_rd) begin
                        head_q <= '0;
                        occ_q  <= FBR_OCC_EMPTY;
                    end
                end
                default: begin
                    // Full: the pop side is blocked, so only a read can happen here.
                    if (do_rd) begin
                        head_q <= tail_q;
                        tail_q <= '0;
                        occ_q  <= FBR_OCC_ONE;
                    end
                end
            endcase
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst pop controller for the team FIFOs with a 2-entry valid/ready output stage.
// Optional idle-timeout burst trigger is built when FIFO_BURST_RD_TIMEOUT_EN is defined.
//
// state     | meaning
// FBR_IDLE  | waiting for fill count >= THRESHOLD (or timeout expiry)
// FBR_DRAIN | popping until MAX_BURST pops or the FIFO runs empty
module fifo_burst_reader
    import fifo_burst_rd_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int BUFFER_DEPTH     = 8,
    parameter int LOG_BUFFER_DEPTH = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1,
    parameter int THRESHOLD        = 4,
    parameter int MAX_BURST        = 8,
    parameter int TIMEOUT          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      fifo_empty_i,
    input  logic [LOG_BUFFER_DEPTH:0] fifo_cnt_i,
    input  logic [DATA_WIDTH-1:0]     fifo_dat_i,
    output logic                      fifo_pop_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_WIDTH-1:0]     dat_o,
    output logic                      busy_o
);

    localparam int CNT_W = LOG_BUFFER_DEPTH + 1;
    localparam logic [CNT_W-1:0] THRESHOLD_C = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

    if (THRESHOLD < 1 || THRESHOLD > BUFFER_DEPTH || MAX_BURST < 1 ||
        MAX_BURST > BUFFER_DEPTH || TIMEOUT < 2) begin : g_bad_params
        $error("fifo_burst_reader: THRESHOLD, MAX_BURST or TIMEOUT out of range");
    end

    fbr_state_e       state_q;
    fbr_state_e       state_d;
    logic [CNT_W-1:0] burst_q;
    fbr_occ_t         occ;
    logic             last_pop;
    logic             tmo_hit;

`ifdef FIFO_BURST_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             tmo_run;

    // Counts only while a partial burst sits in the FIFO waiting for the threshold.
    assign tmo_run = (state_q == FBR_IDLE) && (fifo_cnt_i != '0) && (fifo_cnt_i < THRESHOLD_C);
    assign tmo_hit = tmo_run && (tmo_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            tmo_q <= '0;
        end else if (tmo_run && !tmo_hit) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign last_pop = fifo_pop_o && ((burst_q + CNT_W'(1)) == MAX_BURST_C);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= FBR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FBR_IDLE: begin
                if ((fifo_cnt_i >= THRESHOLD_C) || tmo_hit) begin
                    state_d = FBR_DRAIN;
                end
            end
            FBR_DRAIN: begin
                if (fifo_empty_i || last_pop) begin
                    state_d = FBR_IDLE;
                end
            end
            default: state_d = FBR_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop_o = 1'b0;
        busy_o     = 1'b0;
        if (state_q == FBR_DRAIN) begin
            busy_o     = 1'b1;
            fifo_pop_o = ~fifo_empty_i & (occ != FBR_OCC_FULL) & ~flush_i;
        end
    end

    // Held at zero in IDLE so every burst starts counting from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            burst_q <= '0;
        end else if (state_q == FBR_IDLE) begin
            burst_q <= '0;
        end else if (fifo_pop_o) begin
            burst_q <= burst_q + CNT_W'(1);
        end
    end

    fifo_burst_rd_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .wr_en_i (fifo_pop_o),
        .wr_dat_i(fifo_dat_i),
        .rd_en_i (valid_o & ready_i),
        .occ_o   (occ),
        .head_o  (dat_o)
    );

    assign valid_o = (occ != FBR_OCC_EMPTY);

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Pop-side controller for the team's `fifo` / `stream_fifo` buffers. It watches the FIFO fill count and drains words in bursts once a threshold is reached, and optionally after an idle timeout. Popped words go into a 2-entry output buffer presented as a valid/ready stream. It sits between a FIFO's pop port and a downstream consumer, for example a bus master write engine, and decouples `fifo_pop_o` from downstream `ready_i`.

## Interface
- `DATA_WIDTH`, 32, word width; must equal the attached FIFO's data width.
- `BUFFER_DEPTH`, 8, depth of the attached FIFO; power of two.
- `LOG_BUFFER_DEPTH`, `(BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1`, pointer width of the attached FIFO.
- `THRESHOLD`, 4, fill count that starts a burst; range 1..`BUFFER_DEPTH`.
- `MAX_BURST`, 8, maximum pops per burst; range 1..`BUFFER_DEPTH`.
- `TIMEOUT`, 16, idle cycles before a partial burst is forced; ≥2; used only with `FIFO_BURST_RD_TIMEOUT_EN`.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous flush; the same signal drives the FIFO's `flush_i`.
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `fifo_cnt_i`  in  `LOG_BUFFER_DEPTH+1`  FIFO `cnt_o`.
- `fifo_dat_i`  in  `DATA_WIDTH`  FIFO `dat_o`; the head word is valid combinationally.
- `fifo_pop_o`  out  1  FIFO `pop_i`.
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  downstream ready.
- `dat_o`  out  `DATA_WIDTH`  output word.
- `busy_o`  out  1  high while the FSM is in DRAIN.

## Operation
- FSM has two states: IDLE and DRAIN. Reset and flush both force IDLE.
- IDLE → DRAIN when `fifo_cnt_i >= THRESHOLD`.
- IDLE → DRAIN also on timeout expiry, only when `FIFO_BURST_RD_TIMEOUT_EN` is defined.
- DRAIN → IDLE in the cycle a pop makes the burst count equal `MAX_BURST`.
- DRAIN → IDLE in any cycle with `fifo_empty_i` = 1.
- The burst counter clears on entry to DRAIN and increments on each `fifo_pop_o`. Its width is `LOG_BUFFER_DEPTH+1`.
- `fifo_pop_o = (state == DRAIN) & ~fifo_empty_i & (occ_q != 2) & ~flush_i`, where `occ_q` is output buffer occupancy (0..2).
- `fifo_pop_o` never depends on `ready_i`.
- Output buffer is a 2-entry FIFO-ordered skid buffer.
  - It writes `fifo_dat_i` on pop and reads on `valid_o & ready_i`.
  - `valid_o = (occ_q != 0)`; `dat_o` is the head entry, or 0 when empty.
  - Simultaneous write and read with `occ_q == 1`: occupancy stays 1 and the new word becomes head next cycle.
  - Simultaneous write and read with `occ_q == 2`: cannot occur, because the pop is blocked.
- Words leave in exactly FIFO pop order; none are lost or duplicated.
- `flush_i` for one cycle has these effects next cycle:
  - occupancy 0, `valid_o` = 0, FSM in IDLE;
  - burst and timeout counters at 0;
  - no pop in the flush cycle.
- Reset values: `fifo_pop_o` = 0, `valid_o` = 0, `dat_o` = 0, `busy_o` = 0. All state registers are 0.
- Reset asserted mid-burst behaves as flush; a held downstream word is discarded.

## Timing
- Threshold met in cycle T (registered `fifo_cnt_i`):
  - DRAIN and `busy_o` = 1 in T+1;
  - first `fifo_pop_o` in T+1;
  - first `valid_o` in T+2.
- Pop-to-valid latency is 1 cycle. Sustained throughput is 1 word/cycle with `ready_i` held high.
- With `ready_i` = 0, at most 2 pops occur, then `fifo_pop_o` holds 0 until a word is consumed.
- `dat_o` and `valid_o` are registered outputs. `fifo_pop_o` is combinational from registered state, `fifo_empty_i` and `flush_i`.
- `busy_o` falls the cycle after the last pop of a burst.

## Configuration
- `FIFO_BURST_RD_TIMEOUT_EN` defined:
  - A timeout counter runs in IDLE while `fifo_cnt_i` is nonzero and below `THRESHOLD`.
  - It clears in DRAIN, when the FIFO is empty, or on flush.
  - On reaching `TIMEOUT-1`, the FSM enters DRAIN next cycle.
- Not defined: no timeout counter is instantiated, and fewer than `THRESHOLD` words stay in the FIFO indefinitely.

## Structure
- Package `fifo_burst_rd_pkg` holds:
  - `typedef enum logic [0:0] {FBR_IDLE, FBR_DRAIN} fbr_state_e`;
  - `localparam int FBR_OBUF_DEPTH = 2`.
- Sub-module `fifo_burst_rd_obuf` is the 2-entry skid buffer: data, occupancy, write/read enables, head output.
- The top level holds the FSM, burst counter and optional timeout counter.

## Test plan
- Push 4 words (A0..A3) with `ready_i` = 1, `THRESHOLD` = 4 → DRAIN one cycle after cnt = 4; 4 consecutive pops; `valid_o` high 4 cycles with A0..A3; back to IDLE.
- Push 8 words with `MAX_BURST` = 3 → bursts of 3, 3, 2 with `busy_o` dropping between bursts; output order preserved.
- Hold `ready_i` = 0 in DRAIN with 6 words queued → exactly 2 pops, then `fifo_pop_o` = 0, `fifo_cnt_i` = 4; release `ready_i` → remaining words are delivered in order.
- Define `FIFO_BURST_RD_TIMEOUT_EN`, `TIMEOUT` = 16, push 2 words → DRAIN entered 16 cycles after cnt first becomes nonzero; both words delivered. Without the macro, nothing pops over 100 cycles.
- Assert `flush_i` mid-burst with `occ_q` = 2 → next cycle `valid_o` = 0, IDLE, no pop in the flush cycle. A subsequent 4-word push drains normally.
- Assert `rst_i` during DRAIN → all outputs 0 next cycle; FSM IDLE.
